// File: rtl/noise_gen_if.sv
// Control/sample bundle for one noise voice: the mixer side is master, noise_gen is slave.
// Purely combinational grouping of wires, no latency of its own.
// No backpressure: the voice produces a sample every cycle and the mixer always consumes it.
// Ports: enable/period/mode/seed_load/seed/volume in, noise_out/step_pulse/lfsr_state out.
interface noise_gen_if #(
    parameter int LFSR_W = 15,
    parameter int OUT_W  = 8,
    parameter int DIV_W  = 16
) ();
    logic              enable;
    logic [DIV_W-1:0]  period;
    logic              mode;
    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic [OUT_W-1:0]  volume;
    logic [OUT_W-1:0]  noise_out;
    logic              step_pulse;
    logic [LFSR_W-1:0] lfsr_state;

    modport master (
        output enable, period, mode, seed_load, seed, volume,
        input  noise_out, step_pulse, lfsr_state
    );

    modport slave (
        input  enable, period, mode, seed_load, seed, volume,
        output noise_out, step_pulse, lfsr_state
    );
endinterface

// File: rtl/noise_gen.sv
// Fibonacci-LFSR noise voice with step-rate divider, seed load, lock-up guard and volume scaling.
// Latency: noise_out/step_pulse/lfsr_state all update on the same edge as the LFSR (1 cycle from inputs).
// No backpressure: enable=0 freezes divider and LFSR; outputs are valid every cycle.
// Ports: clk, rst_n (sync, active-low), bus (noise_gen_if.slave).
module noise_gen #(
    parameter int LFSR_W = 15,
    parameter int OUT_W  = 8,
    parameter int DIV_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    noise_gen_if.slave  bus
);

    localparam logic [LFSR_W-1:0] LFSR_ONE = LFSR_W'(1);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  noise_q, noise_d;
    logic              step_q, step_d;

    logic              fb;
    logic [LFSR_W-1:0] lfsr_step;
    logic [LFSR_W-1:0] lfsr_cand;

    always_comb begin
        fb        = lfsr_q[0] ^ (bus.mode ? lfsr_q[6] : lfsr_q[1]);
        lfsr_step = {fb, lfsr_q[LFSR_W-1:1]};

        lfsr_cand = lfsr_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;

        if (bus.seed_load) begin
            lfsr_cand = bus.seed;
            cnt_d     = bus.period;
        end else if (bus.enable) begin
            if (cnt_q == '0) begin
                // New period is only picked up here, so mid-count changes never stretch/shorten the current interval.
                lfsr_cand = lfsr_step;
                cnt_d     = bus.period;
                step_d    = 1'b1;
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end

        // Guard applied to every write, including hold, so a corrupted all-zero state self-recovers.
        lfsr_d  = (lfsr_cand == '0) ? LFSR_ONE : lfsr_cand;
        // Sample follows the post-edge LFSR value, so it lines up with lfsr_state.
        noise_d = lfsr_d[0] ? '0 : bus.volume;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_ONE;
            cnt_q   <= '0;
            noise_q <= '0;
            step_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            noise_q <= noise_d;
            step_q  <= step_d;
        end
    end

    assign bus.noise_out  = noise_q;
    assign bus.step_pulse = step_q;
    assign bus.lfsr_state = lfsr_q;

endmodule

// File: tb/tb_noise_gen.sv
module tb_noise_gen;
    localparam int LW = 15;
    localparam int OW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    noise_gen_if #(.LFSR_W(LW), .OUT_W(OW), .DIV_W(DW)) bus ();

    noise_gen #(.LFSR_W(LW), .OUT_W(OW), .DIV_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b1;

    // Reference model: enabled cycles elapsed since last reload vs the period latched at that reload.
    int m_lfsr, m_ev, m_per, m_noise, m_step;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_next(input int s, input bit m);
        int tap;
        int fb;
        tap = m ? 6 : 1;
        fb  = (s ^ (s >> tap)) & 1;
        return (s >> 1) | (fb << (LW - 1));
    endfunction

    function automatic int guard(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_lfsr = 1; m_ev = 0; m_per = 0; m_noise = 0; m_step = 0;
        end else begin
            m_step = 0;
            if (bus.seed_load) begin
                m_lfsr = guard(int'(bus.seed));
                m_per  = int'(bus.period);
                m_ev   = 0;
            end else if (bus.enable) begin
                if (m_ev == m_per) begin
                    m_lfsr = guard(ref_next(m_lfsr, bus.mode));
                    m_per  = int'(bus.period);
                    m_ev   = 0;
                    m_step = 1;
                end else begin
                    m_ev++;
                end
            end
            m_noise = (m_lfsr & 1) ? 0 : int'(bus.volume);
        end
    endtask

    task automatic cmp_model();
        chk("model_lfsr",  bus.lfsr_state, m_lfsr);
        chk("model_noise", bus.noise_out,  m_noise);
        chk("model_step",  bus.step_pulse, m_step);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (chk_en) cmp_model();
    endtask

    initial begin
        logic [31:0] exp3 [3];
        int n;
        int s;
        bit exp_step;

        exp3[0] = 32'h4000; exp3[1] = 32'h2000; exp3[2] = 32'h1000;

        bus.enable = 1'b0; bus.period = '0; bus.mode = 1'b0;
        bus.seed_load = 1'b0; bus.seed = '0; bus.volume = 8'h80;
        rst_n = 1'b0;

        // Reset and idle hold
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_lfsr",  bus.lfsr_state, 32'h1);
        chk("rst_noise", bus.noise_out,  32'h0);
        chk("rst_step",  bus.step_pulse, 32'h0);
        repeat (20) tick();
        chk("hold_lfsr",  bus.lfsr_state, 32'h1);
        chk("hold_noise", bus.noise_out,  32'h0);

        // Long mode, period 0: first steps and full period length
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.mode = 1'b0; bus.period = '0; bus.enable = 1'b1; bus.volume = 8'hFF;
        n = 0;
        for (int i = 0; i < 40000; i++) begin
            tick();
            if (bus.step_pulse) n++;
            if (bus.step_pulse && n <= 3) begin
                chk("long_seq",   bus.lfsr_state, exp3[n-1]);
                chk("long_noise", bus.noise_out,  32'hFF);
            end
            if (i == 3) chk_en = 1'b0;
            if (bus.lfsr_state == LW'(1)) break;
        end
        chk_en = 1'b1;
        chk("long_len", n, 32767);
        cmp_model();

        // Divider interval, period change mid-count
        bus.period = 16'd3; bus.seed = 15'h0ACE; bus.seed_load = 1'b1; bus.enable = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        chk("pload_step", bus.step_pulse, 32'h0);
        for (int e = 1; e <= 16; e++) begin
            if (e == 10) bus.period = 16'd1;
            tick();
            exp_step = (e == 4) || (e == 8) || (e == 12) || (e == 14) || (e == 16);
            chk("interval", bus.step_pulse, exp_step);
        end

        // Seed loads while disabled, zero-seed guard, volume change without step
        bus.enable = 1'b0; bus.seed = '0; bus.seed_load = 1'b1;
        tick();
        chk("seed0_lfsr", bus.lfsr_state, 32'h1);
        chk("seed0_step", bus.step_pulse, 32'h0);
        bus.seed = 15'h1234;
        tick();
        bus.seed_load = 1'b0;
        chk("seed_lfsr", bus.lfsr_state, 32'h1234);
        chk("seed_step", bus.step_pulse, 32'h0);
        bus.volume = 8'h5A;
        tick();
        chk("vol_nostep", bus.noise_out, 32'h5A);
        repeat (5) tick();
        chk("seed_hold", bus.lfsr_state, 32'h1234);
        bus.enable = 1'b1;
        tick();
        chk("en_first", bus.step_pulse, 32'h0);
        tick();
        chk("en_second", bus.step_pulse, 32'h1);
        chk("en_lfsr",   bus.lfsr_state, 32'h091A);

        // Short mode period, then mode switch without reseed
        bus.mode = 1'b1; bus.period = '0; bus.seed = 15'h0001; bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.step_pulse) n++;
            if (bus.lfsr_state == LW'(1)) break;
        end
        chk("short_len", n, 93);
        repeat (10) tick();
        s = int'(bus.lfsr_state);
        bus.mode = 1'b0;
        tick();
        chk("mode_switch", bus.lfsr_state, ref_next(s, 1'b0));
        repeat (10) tick();

        // Reset in the middle of a count
        bus.period = 16'd5; bus.seed = 15'h0055; bus.seed_load = 1'b1; bus.volume = 8'h3C;
        tick();
        bus.seed_load = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_lfsr",  bus.lfsr_state, 32'h1);
        chk("midrst_noise", bus.noise_out,  32'h0);
        chk("midrst_step",  bus.step_pulse, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("postrst_step",  bus.step_pulse, 32'h1);
        chk("postrst_lfsr",  bus.lfsr_state, 32'h4000);
        chk("postrst_noise", bus.noise_out,  32'h3C);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            bus.enable    = ($urandom_range(0, 3) != 0);
            bus.period    = DW'($urandom_range(0, 7));
            bus.mode      = 1'($urandom);
            bus.seed_load = ($urandom_range(0, 15) == 0);
            bus.seed      = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom);
            bus.volume    = OW'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
